multicycle_control: RTL

- Main control FSM for the 16-bit multi-cycle processor.
- Consumes the opcode/funct of the latched instruction and the ALU flags from the calculations datapath.
- Drives every datapath select and write-enable: ALU op, ALU source A/B, PC source, and PC/IR/register/memory enables.
- Sits between the instruction register and the datapath. It is the controlling end of the datapath's control interface.

---
 rtl/cpu_pkg.sv | 98 +++++++++
 rtl/control_decode.sv | 108 ++++++++++
 rtl/multicycle_control.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit multi-cycle processor: opcodes, ALU operations,
// operand selects, FSM states and the control word the controller drives.
package cpu_pkg;

  localparam logic [3:0] OP_R    = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_ANDI = 4'd2;
  localparam logic [3:0] OP_ORI  = 4'd3;
  localparam logic [3:0] OP_LW   = 4'd4;
  localparam logic [3:0] OP_SW   = 4'd5;
  localparam logic [3:0] OP_BEQ  = 4'd6;
  localparam logic [3:0] OP_BNE  = 4'd7;
  localparam logic [3:0] OP_BLT  = 4'd8;
  localparam logic [3:0] OP_J    = 4'd9;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  localparam logic [1:0] SRCA_PC  = 2'd0;
  localparam logic [1:0] SRCA_TWO = 2'd1;
  localparam logic [1:0] SRCA_REG = 2'd2;
  localparam logic [1:0] SRCB_REG = 2'd0;
  localparam logic [1:0] SRCB_TWO = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_EXEC_R    = 4'd2,
    ST_EXEC_I    = 4'd3,
    ST_ALU_WB    = 4'd4,
    ST_MEM_ADDR  = 4'd5,
    ST_MEM_READ  = 4'd6,
    ST_MEM_WB    = 4'd7,
    ST_MEM_WRITE = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JUMP      = 4'd10,
    ST_HALT      = 4'd11
  } state_e;

  typedef enum logic [2:0] {
    CL_R     = 3'd0,
    CL_IMM   = 3'd1,
    CL_LOAD  = 3'd2,
    CL_STORE = 3'd3,
    CL_BR    = 3'd4,
    CL_JUMP  = 3'd5,
    CL_ILL   = 3'd6
  } op_class_e;

  typedef struct packed {
    logic [2:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_src;
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst_rt;
    logic       halted;
  } ctrl_t;

  // Opcodes wider than the defined space collapse onto an unused (illegal) code.
  function automatic logic [3:0] norm_op(input logic [31:0] op_wide);
    logic [3:0] op4;
    if (op_wide < 32'd16) begin
      op4 = op_wide[3:0];
    end else begin
      op4 = 4'hF;
    end
    return op4;
  endfunction

  function automatic op_class_e op_class(input logic [3:0] op);
    op_class_e cls;
    case (op)
      OP_R:                   cls = CL_R;
      OP_ADDI, OP_ANDI, OP_ORI: cls = CL_IMM;
      OP_LW:                  cls = CL_LOAD;
      OP_SW:                  cls = CL_STORE;
      OP_BEQ, OP_BNE, OP_BLT: cls = CL_BR;
      OP_J:                   cls = CL_JUMP;
      default:                cls = CL_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational map from controller state, instruction fields and ALU flags to
// the datapath control word.
module control_decode
  import cpu_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int FUNCT_W  = 3
) (
  input  state_e              state,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                alu_zero,
  input  logic                alu_negative,
  input  logic                mem_ready,
  output ctrl_t               ctrl
);

  logic [3:0] op_s;
  logic       taken_s;

  assign op_s = norm_op(32'(opcode));

  // Branch condition from the flags of the compare performed in BRANCH.
  always_comb begin
    case (op_s)
      OP_BEQ:  taken_s = alu_zero;
      OP_BNE:  taken_s = ~alu_zero;
      OP_BLT:  taken_s = alu_negative;
      default: taken_s = 1'b0;
    endcase
  end

  // Control word per state; everything not listed stays at the all-zero idle word.
  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_TWO;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
        end else begin
          ctrl.ir_write = 1'b0;
          ctrl.pc_write = 1'b0;
        end
      end
      ST_DECODE: begin
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_IMM;
      end
      ST_EXEC_R: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = 3'(funct);
      end
      ST_EXEC_I: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
        case (op_s)
          OP_ANDI: ctrl.alu_op = ALU_AND;
          OP_ORI:  ctrl.alu_op = ALU_OR;
          default: ctrl.alu_op = ALU_ADD;
        endcase
      end
      ST_ALU_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst_rt = (op_class(op_s) == CL_IMM);
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
      end
      ST_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst_rt = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = 1'b1;
        ctrl.pc_write  = taken_s;
      end
      ST_JUMP: begin
        ctrl.pc_src   = 1'b1;
        ctrl.pc_write = 1'b1;
      end
      ST_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the 16-bit multi-cycle processor: state register and
// next-state logic, with the output decode delegated to control_decode.
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int OPCODE_W     = 4,
  parameter int FUNCT_W      = 3,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                alu_zero,
  input  logic                alu_negative,
  input  logic                mem_ready,
  output logic [2:0]          ALUOp,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic                PCSrc,
  output logic                pc_write,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                reg_dst_rt,
  output logic                halted,
  output logic [3:0]          state_out
);

  state_e    state_q;
  state_e    state_d;
  op_class_e cls_s;
  ctrl_t     dec_s;
  ctrl_t     ctrl_s;

  assign cls_s = op_class(norm_op(32'(opcode)));

  control_decode #(
    .OPCODE_W (OPCODE_W),
    .FUNCT_W  (FUNCT_W)
  ) u_decode (
    .state        (state_q),
    .opcode       (opcode),
    .funct        (funct),
    .alu_zero     (alu_zero),
    .alu_negative (alu_negative),
    .mem_ready    (mem_ready),
    .ctrl         (dec_s)
  );

  // Next-state logic; mem_ready only matters in the three memory-access states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (cls_s)
          CL_R:             state_d = ST_EXEC_R;
          CL_IMM:           state_d = ST_EXEC_I;
          CL_LOAD, CL_STORE: state_d = ST_MEM_ADDR;
          CL_BR:            state_d = ST_BRANCH;
          CL_JUMP:          state_d = ST_JUMP;
          default: begin
            if (ILLEGAL_HALT) begin
              state_d = ST_HALT;
            end else begin
              state_d = ST_FETCH;
            end
          end
        endcase
      end
      ST_EXEC_R, ST_EXEC_I: state_d = ST_ALU_WB;
      ST_MEM_ADDR: begin
        if (cls_s == CL_LOAD) begin
          state_d = ST_MEM_READ;
        end else begin
          state_d = ST_MEM_WRITE;
        end
      end
      ST_MEM_READ: begin
        if (mem_ready) begin
          state_d = ST_MEM_WB;
        end else begin
          state_d = ST_MEM_READ;
        end
      end
      ST_MEM_WRITE: begin
        if (mem_ready) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_MEM_WRITE;
        end
      end
      ST_ALU_WB, ST_MEM_WB, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_FETCH;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset kills every strobe in the same cycle so an abandoned instruction writes nothing.
  always_comb begin
    if (reset) begin
      ctrl_s = '0;
    end else begin
      ctrl_s = dec_s;
    end
  end

  assign ALUOp      = ctrl_s.alu_op;
  assign ALUSrcA    = ctrl_s.alu_src_a;
  assign ALUSrcB    = ctrl_s.alu_src_b;
  assign PCSrc      = ctrl_s.pc_src;
  assign pc_write   = ctrl_s.pc_write;
  assign ir_write   = ctrl_s.ir_write;
  assign i_or_d     = ctrl_s.i_or_d;
  assign mem_read   = ctrl_s.mem_read;
  assign mem_write  = ctrl_s.mem_write;
  assign reg_write  = ctrl_s.reg_write;
  assign mem_to_reg = ctrl_s.mem_to_reg;
  assign reg_dst_rt = ctrl_s.reg_dst_rt;
  assign halted     = ctrl_s.halted;
  assign state_out  = state_q;

endmodule
